gba_line_cache: RTL and testbench
=================================

// Module: gba_line_cache
// PURPOSE
// - Write/serve side of the line cache feeding imageGenV.
// - Stores captured GBA pixels (240x160, 24b RGB) in a ring of line buffers.
// - Serves the 3x3 neighbourhood around the pixel index requested by the image generator.
// - Follows the generator's nextLine/cacheUpdate handshake and reports sameLine back so output never overtakes capture.
// PARAMETERS
// - LINE_PXLS  240  pixels per GBA line
// - FRAME_LNS  160  lines per GBA frame
// - NUM_LINES  4    ring depth in lines (>=4)
// PORTS
// - pxlClk        in   1    pixel clock
// - rst           in   1    synchronous reset, active-high
// - wrValid       in   1    capture pixel strobe (already in pxlClk domain)
// - wrRGB         in   24   {R,G,B} of captured pixel
// - wrFrameStart  in   1    pulse: first pixel of a new GBA frame follows
// - rdPxl         in   8    requested pixel index (curPxl)
// - rdNextLine    in   1    pulse: advance read line (nextLine)
// - rdCacheUpdate in   1    pulse: commit read line to window rows (cacheUpdate)
// - winRGB        out  216  3x3 window, slot = row*3+col, row0=prev line, col0=prev pxl, 24b each
// - sameLine      out  1    1 = next read line not yet completely written
// - newFrameOut   out  1    1-cycle pulse, 1 cycle after wrFrameStart
// - overflow      out  1    sticky: writer overwrote a line still in the window
// BEHAVIOUR
// - Reset: winRGB=0, sameLine=1, newFrameOut=0, overflow=0.
//   Reset also clears wLine, wPxl, rLine, rY, fill and the committed row registers; RAM contents are undefined.
// - Write path:
//   - wrValid stores wrRGB at [wLine][wPxl], then wPxl++.
//   - At wPxl==LINE_PXLS-1: wPxl<=0, wLine<=(wLine+1)%NUM_LINES, fill++.
// - wrFrameStart:
//   - wLine, wPxl, rLine, rY and fill <= 0; overflow cleared.
//   - Takes priority over a same-cycle wrValid (that pixel is dropped).
// - fill counts completed, unconsumed lines (0..NUM_LINES).
//   - sameLine = (fill<2); registered, updates 1 cycle after fill changes.
// - Read line advance:
//   - rdNextLine: if fill>=2, rLine++ (mod NUM_LINES), rY++ (saturate FRAME_LNS-1), fill--.
//   - If fill<2, rdNextLine is ignored; no error is raised.
// - Simultaneous write line-complete and accepted rdNextLine: fill unchanged.
// - Window row commit:
//   - rdCacheUpdate copies rLine/rY into committed registers cLine/cY.
//   - Window rows use cLine-1, cLine, cLine+1 (mod NUM_LINES).
//   - rdNextLine and rdCacheUpdate in the same cycle: commit uses the post-advance rLine.
// - Edge clamp (macro off):
//   - cY==0: row0 = cur row.
//   - cY==FRAME_LNS-1: row2 = cur row.
//   - rdPxl==0: col0 = col1.
//   - rdPxl>=LINE_PXLS-1: col2 = col1.
//   - rdPxl>LINE_PXLS-1 is treated as LINE_PXLS-1.
// - Latency: rdPxl sampled at cycle n -> winRGB valid at n+2 (RAM read stage + output register); fully pipelined, 1 window/cycle.
// - Overflow: a line completes while fill==NUM_LINES-1 -> overflow<=1. The line is still written (oldest overwritten).
// - Read-during-write to the same address returns old data.
//   Generator timing never reads the line being written unless overflow is set.
// CONFIGURATION
// - LINECACHE_BORDER_ZERO_EN defined: every out-of-frame neighbour slot (the clamp cases above) outputs 24'h000000 instead of the clamped pixel.
//   Latency is unchanged.
// - Undefined: edge-clamp replication as described.
// TESTING
// - Reset, then idle 10 cycles -> winRGB=0, sameLine=1, newFrameOut=0, overflow=0.
// - wrFrameStart, then 2 lines where pixel p of line L = {L,p,8'hA5}:
//   - sameLine falls after line 2 completes.
//   - rdCacheUpdate, rdPxl=5 -> after 2 cycles slot4={0,5,A5}, slot5={0,6,A5}, slot7={1,5,A5}, slot1=slot4 (clamp).
// - Column edges: rdPxl=0 -> slot3==slot4; rdPxl=239 -> slot5==slot4.
//   With LINECACHE_BORDER_ZERO_EN: slot3/slot5 and row0 slots = 0.
// - Write line-complete and rdNextLine in the same cycle with fill=2 -> fill stays 2, sameLine stays 0, rLine advances by 1.
// - Stall the reader and write 4 full lines after frame start -> overflow=1 at completion of line 4, stays 1 until wrFrameStart.
// - Mid-line wrFrameStart at wPxl=100 -> next wrValid writes [0][0], newFrameOut pulses once, sameLine=1.

Source files
------------

// File: rtl/gba_line_cache.sv
// gba_line_cache: ring of captured GBA lines serving a 3x3 window to the image generator.
// Define LINECACHE_BORDER_ZERO_EN to output zero for out-of-frame neighbours instead of edge replication.
module gba_line_cache #(
  parameter int LINE_PXLS = 240,
  parameter int FRAME_LNS = 160,
  parameter int NUM_LINES = 4
) (
  input  logic         pxlClk,
  input  logic         rst,
  input  logic         wrValid,
  input  logic [23:0]  wrRGB,
  input  logic         wrFrameStart,
  input  logic [7:0]   rdPxl,
  input  logic         rdNextLine,
  input  logic         rdCacheUpdate,
  output logic [215:0] winRGB,
  output logic         sameLine,
  output logic         newFrameOut,
  output logic         overflow
);
  localparam int LW = $clog2(NUM_LINES);
  localparam int YW = $clog2(FRAME_LNS);
  localparam int FW = $clog2(NUM_LINES + 1);
  localparam int AW = $clog2(NUM_LINES * LINE_PXLS);
`ifdef LINECACHE_BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif
  function automatic logic [LW-1:0] line_inc(input logic [LW-1:0] l);
    return l == LW'(NUM_LINES - 1) ? '0 : l + 1'b1;
  endfunction
  function automatic logic [LW-1:0] line_dec(input logic [LW-1:0] l);
    return l == '0 ? LW'(NUM_LINES - 1) : l - 1'b1;
  endfunction
  function automatic logic [AW-1:0] addr(input logic [LW-1:0] l, input logic [7:0] p);
    return AW'(l) * AW'(LINE_PXLS) + AW'(p);
  endfunction
  logic [23:0]    mem [NUM_LINES*LINE_PXLS];
  logic [LW-1:0]  w_line, r_line, c_line, r_line_n;
  logic [7:0]     w_pxl, px;
  logic [YW-1:0]  r_y, c_y, r_y_n;
  logic [FW-1:0]  fill, fill_n;
  logic           wr_en, line_done, adv;
  logic [LW-1:0]  rows [3];
  logic [7:0]     cols [3];
  logic [3:0]     edg, edg_q;
  logic [215:0]   win_d;
  // edg = {top, bottom, left, right}: which window sides fall outside the frame
  always_comb begin
    wr_en = wrValid && !wrFrameStart;
    line_done = wr_en && w_pxl == 8'(LINE_PXLS - 1);
    adv = rdNextLine && !wrFrameStart && fill >= FW'(2);
    r_line_n = wrFrameStart ? '0 : adv ? line_inc(r_line) : r_line;
    r_y_n = wrFrameStart ? '0 : (adv && r_y != YW'(FRAME_LNS - 1)) ? r_y + 1'b1 : r_y;
    fill_n = (line_done && !adv && fill != FW'(NUM_LINES)) ? fill + 1'b1 :
             (adv && !line_done) ? fill - 1'b1 : fill;
    px = rdPxl >= 8'(LINE_PXLS - 1) ? 8'(LINE_PXLS - 1) : rdPxl;
    edg = {c_y == '0, c_y == YW'(FRAME_LNS - 1), px == '0, px == 8'(LINE_PXLS - 1)};
    rows[0] = edg[3] ? c_line : line_dec(c_line);
    rows[1] = c_line;
    rows[2] = edg[2] ? c_line : line_inc(c_line);
    cols[0] = edg[1] ? px : px - 8'd1;
    cols[1] = px;
    cols[2] = edg[0] ? px : px + 8'd1;
  end
  always_ff @(posedge pxlClk)
    if (wr_en) mem[addr(w_line, w_pxl)] <= wrRGB;
  always_ff @(posedge pxlClk) edg_q <= edg;
  for (genvar s = 0; s < 9; s++) begin : g_rd
    localparam int R = s / 3;
    localparam int C = s % 3;
    logic [23:0] q;
    always_ff @(posedge pxlClk) q <= mem[addr(rows[R], cols[C])];
    assign win_d[s*24 +: 24] = (BZ && ((R == 0 && edg_q[3]) || (R == 2 && edg_q[2]) ||
                                       (C == 0 && edg_q[1]) || (C == 2 && edg_q[0]))) ? '0 : q;
  end
  always_ff @(posedge pxlClk) winRGB <= rst ? '0 : win_d;
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      w_line <= '0;
      w_pxl <= '0;
      r_line <= '0;
      r_y <= '0;
      c_line <= '0;
      c_y <= '0;
      fill <= '0;
      sameLine <= 1'b1;
      newFrameOut <= 1'b0;
      overflow <= 1'b0;
    end else begin
      newFrameOut <= wrFrameStart;
      sameLine <= fill < FW'(2);
      r_line <= r_line_n;
      r_y <= r_y_n;
      if (rdCacheUpdate) begin
        c_line <= r_line_n;
        c_y <= r_y_n;
      end
      if (wrFrameStart) begin
        w_line <= '0;
        w_pxl <= '0;
        fill <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) w_pxl <= line_done ? '0 : w_pxl + 8'd1;
        if (line_done) w_line <= line_inc(w_line);
        if (line_done && fill == FW'(NUM_LINES - 1)) overflow <= 1'b1;
        fill <= fill_n;
      end
    end
  end
endmodule

// File: tb/tb_gba_line_cache.sv
// tb_gba_line_cache: directed stimulus with a pixel-coordinate model of the line cache checked every cycle.
module tb_gba_line_cache;
  localparam int LP = 240;
  localparam int FL = 160;
  localparam int NL = 4;
`ifdef LINECACHE_BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif
  logic pxlClk = 0, rst = 1, wrValid = 0, wrFrameStart = 0, rdNextLine = 0, rdCacheUpdate = 0;
  logic [23:0] wrRGB = '0;
  logic [7:0] rdPxl = '0;
  logic [215:0] winRGB;
  logic sameLine, newFrameOut, overflow;
  always #5 pxlClk = ~pxlClk;
  gba_line_cache dut (
    .pxlClk(pxlClk), .rst(rst), .wrValid(wrValid), .wrRGB(wrRGB), .wrFrameStart(wrFrameStart),
    .rdPxl(rdPxl), .rdNextLine(rdNextLine), .rdCacheUpdate(rdCacheUpdate),
    .winRGB(winRGB), .sameLine(sameLine), .newFrameOut(newFrameOut), .overflow(overflow)
  );
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [23:0] pix(input int l, input int p);
    return {l[7:0], p[7:0], 8'hA5};
  endfunction
  function automatic logic [23:0] slot(input int s);
    return winRGB[s*24 +: 24];
  endfunction
  logic [23:0] m_mem [NL][LP];
  bit m_kn [NL][LP];
  int m_wl, m_wp, m_rl, m_ry, m_cl, m_cy, m_fill;
  bit m_ovf;
  logic [23:0] e_win [9], p_win [9];
  bit e_kn [9], p_kn [9];
  bit e_same, e_nfo, e_ovf, chk_en = 0;
  // Model: window = frame coordinates (cY-1..cY+1, px-1..px+1), clamped or zeroed at frame edges
  always @(posedge pxlClk) begin : model
    int px, dy, x, y, ln;
    bit done, acc;
    e_win = p_win;
    e_kn = p_kn;
    e_same = rst || m_fill < 2;
    e_nfo = !rst && wrFrameStart;
    if (rst) begin
      for (int s = 0; s < 9; s++) begin
        e_win[s] = '0;
        e_kn[s] = 1;
        p_kn[s] = 0;
      end
    end else begin
      px = rdPxl > LP - 1 ? LP - 1 : int'(rdPxl);
      for (int s = 0; s < 9; s++) begin
        dy = s / 3 - 1;
        y = m_cy + dy;
        x = px + s % 3 - 1;
        if (BZ && (y < 0 || y > FL - 1 || x < 0 || x > LP - 1)) begin
          p_win[s] = '0;
          p_kn[s] = 1;
        end else begin
          if (y < 0 || y > FL - 1) dy = 0;
          if (x < 0 || x > LP - 1) x = px;
          ln = (m_cl + dy + NL) % NL;
          p_win[s] = m_mem[ln][x];
          p_kn[s] = m_kn[ln][x];
        end
      end
    end
    if (rst) begin
      {m_wl, m_wp, m_rl, m_ry, m_cl, m_cy, m_fill} = '0;
      m_ovf = 0;
    end else if (wrFrameStart) begin
      {m_wl, m_wp, m_rl, m_ry, m_fill} = '0;
      m_ovf = 0;
      if (rdCacheUpdate) {m_cl, m_cy} = '0;
    end else begin
      done = wrValid && m_wp == LP - 1;
      acc = rdNextLine && m_fill >= 2;
      if (wrValid) begin
        m_mem[m_wl][m_wp] = wrRGB;
        m_kn[m_wl][m_wp] = 1;
        if (done) begin
          if (m_fill == NL - 1) m_ovf = 1;
          m_wp = 0;
          m_wl = (m_wl + 1) % NL;
        end else m_wp++;
      end
      if (acc) begin
        m_rl = (m_rl + 1) % NL;
        if (m_ry < FL - 1) m_ry++;
      end
      m_fill = m_fill + int'(done) - int'(acc);
      if (m_fill > NL) m_fill = NL;
      if (rdCacheUpdate) begin
        m_cl = m_rl;
        m_cy = m_ry;
      end
    end
    e_ovf = m_ovf;
  end
  always @(negedge pxlClk) if (chk_en) begin
    check("sameLine", 24'(sameLine), 24'(e_same));
    check("newFrameOut", 24'(newFrameOut), 24'(e_nfo));
    check("overflow", 24'(overflow), 24'(e_ovf));
    for (int s = 0; s < 9; s++)
      if (e_kn[s]) check($sformatf("win_slot%0d", s), slot(s), e_win[s]);
  end
  task automatic write_line(input int l, input int n, input bit adv_last);
    for (int p = 0; p < n; p++) begin
      @(negedge pxlClk);
      wrValid = 1;
      wrRGB = pix(l, p);
      rdNextLine = adv_last && p == n - 1;
    end
    @(negedge pxlClk);
    wrValid = 0;
    rdNextLine = 0;
  endtask
  task automatic frame_start();
    @(negedge pxlClk);
    wrFrameStart = 1;
    @(negedge pxlClk);
    wrFrameStart = 0;
  endtask
  task automatic commit();
    @(negedge pxlClk);
    rdCacheUpdate = 1;
    @(negedge pxlClk);
    rdCacheUpdate = 0;
  endtask
  task automatic read_at(input int p);
    rdPxl = 8'(p);
    @(negedge pxlClk);
    @(negedge pxlClk);
    #1;
  endtask
  initial begin
    @(posedge pxlClk);
    chk_en = 1;
    @(negedge pxlClk);
    rst = 0;
    repeat (10) @(negedge pxlClk);
    check("rst_win_nonzero", 24'(|winRGB), 24'd0);
    check("rst_sameLine", 24'(sameLine), 24'd1);
    check("rst_newFrameOut", 24'(newFrameOut), 24'd0);
    check("rst_overflow", 24'(overflow), 24'd0);
    frame_start();
    check("fs_pulse", 24'(newFrameOut), 24'd1);
    write_line(0, LP, 0);
    write_line(1, LP, 0);
    check("same_before_fall", 24'(sameLine), 24'd1);
    @(negedge pxlClk);
    check("same_fall", 24'(sameLine), 24'd0);
    @(negedge pxlClk);
    rdCacheUpdate = 1;
    @(negedge pxlClk);
    rdCacheUpdate = 0;
    read_at(5);
    check("p5_slot4", slot(4), 24'h0005A5);
    check("p5_slot5", slot(5), 24'h0006A5);
    check("p5_slot3", slot(3), 24'h0004A5);
    check("p5_slot7", slot(7), 24'h0105A5);
    check("p5_slot8", slot(8), 24'h0106A5);
    check("p5_slot1_top", slot(1), BZ ? 24'h0 : 24'h0005A5);
    read_at(0);
    check("p0_slot4", slot(4), 24'h0000A5);
    check("p0_slot3_left", slot(3), BZ ? 24'h0 : 24'h0000A5);
    check("p0_slot0_corner", slot(0), BZ ? 24'h0 : 24'h0000A5);
    read_at(239);
    check("p239_slot4", slot(4), 24'h00EFA5);
    check("p239_slot5_right", slot(5), BZ ? 24'h0 : 24'h00EFA5);
    check("p239_slot8", slot(8), BZ ? 24'h0 : 24'h01EFA5);
    read_at(250);
    check("p250_slot4", slot(4), 24'h00EFA5);
    check("p250_slot3", slot(3), 24'h00EEA5);
    write_line(2, LP, 1);
    @(negedge pxlClk);
    check("same_hold", 24'(sameLine), 24'd0);
    commit();
    read_at(10);
    check("adv_slot1", slot(1), 24'h000AA5);
    check("adv_slot4", slot(4), 24'h010AA5);
    check("adv_slot7", slot(7), 24'h020AA5);
    @(negedge pxlClk);
    rdNextLine = 1;
    rdCacheUpdate = 1;
    @(negedge pxlClk);
    rdNextLine = 0;
    rdCacheUpdate = 0;
    read_at(10);
    check("adv2_slot1", slot(1), 24'h010AA5);
    check("adv2_slot4", slot(4), 24'h020AA5);
    check("same_rise", 24'(sameLine), 24'd1);
    frame_start();
    for (int l = 0; l < 3; l++) write_line(l, LP, 0);
    check("ovf_pre", 24'(overflow), 24'd0);
    write_line(3, LP, 0);
    check("ovf_set", 24'(overflow), 24'd1);
    repeat (5) @(negedge pxlClk);
    check("ovf_sticky", 24'(overflow), 24'd1);
    frame_start();
    check("ovf_clr", 24'(overflow), 24'd0);
    write_line(7, 100, 0);
    @(negedge pxlClk);
    wrFrameStart = 1;
    wrValid = 1;
    wrRGB = 24'hDEAD00;
    @(negedge pxlClk);
    wrFrameStart = 0;
    wrValid = 0;
    check("mid_nfo", 24'(newFrameOut), 24'd1);
    @(negedge pxlClk);
    check("mid_nfo_once", 24'(newFrameOut), 24'd0);
    check("mid_same", 24'(sameLine), 24'd1);
    write_line(80, LP, 0);
    write_line(81, LP, 0);
    commit();
    read_at(0);
    check("mid_00", slot(4), 24'h5000A5);
    check("mid_row2", slot(7), 24'h5100A5);
    @(negedge pxlClk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
